text_cursor_feeder: RTL and testbench

- Parametrised successor to the team's character feeder.
- Accepts 8-bit character codes over a valid/ready handshake and maps them to glyph indices.
- Drives a registered write port into a ROWS x COLS character RAM and tracks the cursor.
- Adds control codes (backspace, newline, clear), a multi-cycle clear sweep, and selectable end-of-screen policy (wrap or stop).

---
 rtl/text_cursor_feeder_pkg.sv | 30 +++
 rtl/text_cursor_feeder_if.sv | 9 +
 rtl/text_cursor_feeder_glyph_mapper.sv | 26 ++
 rtl/text_cursor_feeder.sv | 210 +++++++++++++++++++++
 tb/tb_text_cursor_feeder.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/text_cursor_feeder_pkg.sv
// Shared constants and types for the text cursor feeder and its glyph mapper.
package text_feeder_pkg;

  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_CLR = 8'hFF;
  localparam logic [7:0] CH_SP  = 8'h20;

  localparam logic [7:0] CH_DIGIT_LO = 8'h30;
  localparam logic [7:0] CH_DIGIT_HI = 8'h39;
  localparam logic [7:0] CH_UPPER_LO = 8'h41;
  localparam logic [7:0] CH_UPPER_HI = 8'h5A;
  localparam logic [7:0] CH_LOWER_LO = 8'h61;
  localparam logic [7:0] CH_LOWER_HI = 8'h7A;
  localparam logic [7:0] CH_EXT_LO   = 8'h80;
  localparam logic [7:0] CH_EXT_HI   = 8'hBD;

  localparam logic [7:0] G_DIGIT_BASE = 8'd0;
  localparam logic [7:0] G_UPPER_BASE = 8'd10;
  localparam logic [7:0] G_LOWER_BASE = 8'd36;
  localparam logic [7:0] G_EXT_BASE   = 8'd62;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_FULL} state_t;

  function automatic logic in_range(input logic [7:0] c, input logic [7:0] lo,
                                    input logic [7:0] hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/text_cursor_feeder_if.sv
// Character input handshake: producer drives valid/char, feeder returns ready.
interface text_cursor_feeder_if;
  logic       in_valid;
  logic [7:0] in_char;
  logic       in_ready;

  modport master (output in_valid, output in_char, input in_ready);
  modport slave  (input in_valid, input in_char, output in_ready);
endinterface

// File: rtl/text_cursor_feeder_glyph_mapper.sv
// Combinational character-code to glyph-index map, shared with the display front end.
module glyph_mapper
  import text_feeder_pkg::*;
#(
  parameter logic [7:0] BLANK_GLYPH   = 8'hFE,
  parameter logic [7:0] UNKNOWN_GLYPH = 8'h80
) (
  input  logic [7:0] char_i,
  output logic [7:0] glyph_o
);

  always_comb begin
    glyph_o = UNKNOWN_GLYPH;
    if (in_range(char_i, CH_DIGIT_LO, CH_DIGIT_HI))
      glyph_o = char_i - CH_DIGIT_LO + G_DIGIT_BASE;
    else if (in_range(char_i, CH_UPPER_LO, CH_UPPER_HI))
      glyph_o = char_i - CH_UPPER_LO + G_UPPER_BASE;
    else if (in_range(char_i, CH_LOWER_LO, CH_LOWER_HI))
      glyph_o = char_i - CH_LOWER_LO + G_LOWER_BASE;
    else if (in_range(char_i, CH_EXT_LO, CH_EXT_HI))
      glyph_o = char_i - CH_EXT_LO + G_EXT_BASE;
    else if (char_i == CH_SP)
      glyph_o = BLANK_GLYPH;
  end

endmodule

// File: rtl/text_cursor_feeder.sv
// Character feeder: maps accepted codes to glyphs, writes them into a ROWS x COLS
// character RAM at the cursor, and handles backspace, newline and a clear sweep.
module text_cursor_feeder
  import text_feeder_pkg::*;
#(
  parameter int          COLS           = 20,
  parameter int          ROWS           = 7,
  parameter int          WRAP_MODE      = 0,
  parameter int          CLEAR_ON_RESET = 1,
  parameter logic [7:0]  BLANK_GLYPH    = 8'hFE,
  parameter logic [7:0]  UNKNOWN_GLYPH  = 8'h80,
  localparam int         CW_R           = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int         CW_C           = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  text_cursor_feeder_if.slave in_if,
  output logic                wr_en,
  output logic [CW_R-1:0]     wr_row,
  output logic [CW_C-1:0]     wr_col,
  output logic [7:0]          wr_glyph,
  output logic [CW_R-1:0]     cur_row,
  output logic [CW_C-1:0]     cur_col,
  output logic                screen_full,
  output logic                dropped,
  output logic                clear_done
);

  localparam logic [CW_R-1:0] LAST_ROW = CW_R'(ROWS - 1);
  localparam logic [CW_C-1:0] LAST_COL = CW_C'(COLS - 1);
  localparam logic [CW_R-1:0] ONE_R    = CW_R'(1);
  localparam logic [CW_C-1:0] ONE_C    = CW_C'(1);

  state_t            state_q, state_d;
  logic [CW_R-1:0]   cur_row_q, cur_row_d, sw_row_q, sw_row_d, wr_row_q, wr_row_d;
  logic [CW_C-1:0]   cur_col_q, cur_col_d, sw_col_q, sw_col_d, wr_col_q, wr_col_d;
  logic [7:0]        wr_glyph_q, wr_glyph_d, map_glyph;
  logic              wr_en_q, wr_en_d, full_q, full_d, drop_q, drop_d;
  logic              done_q, done_d, in_ready_q, in_ready_d;
  logic              xfer, at_last_row, at_last_col, eos;

  glyph_mapper #(.BLANK_GLYPH(BLANK_GLYPH), .UNKNOWN_GLYPH(UNKNOWN_GLYPH)) u_map (
    .char_i (in_if.in_char),
    .glyph_o(map_glyph)
  );

  assign xfer        = in_if.in_valid && in_ready_q;
  assign at_last_row = (cur_row_q == LAST_ROW);
  assign at_last_col = (cur_col_q == LAST_COL);

  always_comb begin
    state_d    = state_q;
    cur_row_d  = cur_row_q;
    cur_col_d  = cur_col_q;
    sw_row_d   = sw_row_q;
    sw_col_d   = sw_col_q;
    wr_en_d    = 1'b0;
    wr_row_d   = wr_row_q;
    wr_col_d   = wr_col_q;
    wr_glyph_d = wr_glyph_q;
    full_d     = 1'b0;
    drop_d     = 1'b0;
    done_d     = 1'b0;
    eos        = 1'b0;
    case (state_q)
      S_CLEAR: begin
        wr_en_d    = 1'b1;
        wr_row_d   = sw_row_q;
        wr_col_d   = sw_col_q;
        wr_glyph_d = BLANK_GLYPH;
        if (sw_col_q == LAST_COL) begin
          sw_col_d = '0;
          if (sw_row_q == LAST_ROW) begin
            sw_row_d  = '0;
            done_d    = 1'b1;
            state_d   = S_IDLE;
            cur_row_d = '0;
            cur_col_d = '0;
          end else begin
            sw_row_d = sw_row_q + ONE_R;
          end
        end else begin
          sw_col_d = sw_col_q + ONE_C;
        end
      end
      S_FULL: begin
        if (xfer) begin
          if (in_if.in_char == CH_CLR) begin
            state_d  = S_CLEAR;
            sw_row_d = '0;
            sw_col_d = '0;
          end else if (in_if.in_char == CH_BS) begin
            // Cursor stays parked on the last cell so the next char overwrites it.
            wr_en_d    = 1'b1;
            wr_row_d   = LAST_ROW;
            wr_col_d   = LAST_COL;
            wr_glyph_d = BLANK_GLYPH;
            state_d    = S_IDLE;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      default: begin
        if (xfer) begin
          case (in_if.in_char)
            CH_CLR: begin
              state_d  = S_CLEAR;
              sw_row_d = '0;
              sw_col_d = '0;
            end
            CH_LF: begin
              if (at_last_row) begin
                eos = 1'b1;
              end else begin
                cur_col_d = '0;
                cur_row_d = cur_row_q + ONE_R;
              end
            end
            CH_BS: begin
              if ((cur_row_q != '0) || (cur_col_q != '0)) begin
                if (cur_col_q == '0) begin
                  cur_row_d = cur_row_q - ONE_R;
                  cur_col_d = LAST_COL;
                end else begin
                  cur_col_d = cur_col_q - ONE_C;
                end
                wr_en_d    = 1'b1;
                wr_row_d   = cur_row_d;
                wr_col_d   = cur_col_d;
                wr_glyph_d = BLANK_GLYPH;
              end
            end
            default: begin
              wr_en_d    = 1'b1;
              wr_row_d   = cur_row_q;
              wr_col_d   = cur_col_q;
              wr_glyph_d = map_glyph;
              if (at_last_col && at_last_row) begin
                eos = 1'b1;
              end else if (at_last_col) begin
                cur_col_d = '0;
                cur_row_d = cur_row_q + ONE_R;
              end else begin
                cur_col_d = cur_col_q + ONE_C;
              end
            end
          endcase
        end
      end
    endcase
    if (eos) begin
      full_d = 1'b1;
      if (WRAP_MODE == 0) begin
        cur_row_d = '0;
        cur_col_d = '0;
      end else begin
        cur_row_d = LAST_ROW;
        cur_col_d = LAST_COL;
        state_d   = S_FULL;
      end
    end
    // Ready stays low for one cycle after a sweep so clear_done is seen before new input.
    in_ready_d = (state_d != S_CLEAR) && (state_q != S_CLEAR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      cur_row_q  <= '0;
      cur_col_q  <= '0;
      sw_row_q   <= '0;
      sw_col_q   <= '0;
      wr_en_q    <= 1'b0;
      wr_row_q   <= '0;
      wr_col_q   <= '0;
      wr_glyph_q <= '0;
      full_q     <= 1'b0;
      drop_q     <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_row_q  <= cur_row_d;
      cur_col_q  <= cur_col_d;
      sw_row_q   <= sw_row_d;
      sw_col_q   <= sw_col_d;
      wr_en_q    <= wr_en_d;
      wr_row_q   <= wr_row_d;
      wr_col_q   <= wr_col_d;
      wr_glyph_q <= wr_glyph_d;
      full_q     <= full_d;
      drop_q     <= drop_d;
      done_q     <= done_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign wr_en          = wr_en_q;
  assign wr_row         = wr_row_q;
  assign wr_col         = wr_col_q;
  assign wr_glyph       = wr_glyph_q;
  assign cur_row        = cur_row_q;
  assign cur_col        = cur_col_q;
  assign screen_full    = full_q;
  assign dropped        = drop_q;
  assign clear_done     = done_q;

endmodule

// File: tb/tb_text_cursor_feeder.sv
// Scoreboard bench: dut0 runs in wrap mode, dut1 in stop mode, both with default geometry.
module tb_text_cursor_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n = 1'b1, rst1_n = 1'b1;
  text_cursor_feeder_if if0 ();
  text_cursor_feeder_if if1 ();

  logic       wr_en0, sf0, dr0, cd0, wr_en1, sf1, dr1, cd1;
  logic [2:0] wr_row0, cur_row0, wr_row1, cur_row1;
  logic [4:0] wr_col0, cur_col0, wr_col1, cur_col1;
  logic [7:0] wr_glyph0, wr_glyph1;

  text_cursor_feeder #(.WRAP_MODE(0)) dut0 (
    .clk(clk), .reset_n(rst0_n), .in_if(if0),
    .wr_en(wr_en0), .wr_row(wr_row0), .wr_col(wr_col0), .wr_glyph(wr_glyph0),
    .cur_row(cur_row0), .cur_col(cur_col0),
    .screen_full(sf0), .dropped(dr0), .clear_done(cd0)
  );

  text_cursor_feeder #(.WRAP_MODE(1)) dut1 (
    .clk(clk), .reset_n(rst1_n), .in_if(if1),
    .wr_en(wr_en1), .wr_row(wr_row1), .wr_col(wr_col1), .wr_glyph(wr_glyph1),
    .cur_row(cur_row1), .cur_col(cur_col1),
    .screen_full(sf1), .dropped(dr1), .clear_done(cd1)
  );

  typedef struct packed {
    logic       wr;
    logic [2:0] row;
    logic [4:0] col;
    logic [7:0] g;
    logic       sf;
    logic       dr;
    logic       cd;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ev_t wev(input int r, input int c, input int g, input bit sf, input bit cd);
    return '{1'b1, 3'(r), 5'(c), 8'(g), sf, 1'b0, cd};
  endfunction

  function automatic ev_t fev(input bit sf, input bit dr);
    return '{1'b0, 3'd0, 5'd0, 8'd0, sf, dr, 1'b0};
  endfunction

  task automatic push(input int d, input ev_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic push_clear(input int d, input int n);
    for (int i = 0; i < n; i++) push(d, wev(i / 20, i % 20, 8'hFE, 1'b0, i == 139));
  endtask

  // Monitor: every output event is popped from the scoreboard and compared whole.
  task automatic mon(input int d, input logic w, input logic [2:0] r, input logic [4:0] c,
                     input logic [7:0] g, input logic sf, input logic dr, input logic cd);
    ev_t a, e;
    a = '{w, w ? r : 3'd0, w ? c : 5'd0, w ? g : 8'd0, sf, dr, cd};
    if (d == 0) begin
      if (q0.size() == 0) begin check("dut0_unexpected_event", q0.size(), 1); return; end
      e = q0.pop_front();
      check("dut0_event", 32'(a), 32'(e));
    end else begin
      if (q1.size() == 0) begin check("dut1_unexpected_event", q1.size(), 1); return; end
      e = q1.pop_front();
      check("dut1_event", 32'(a), 32'(e));
    end
  endtask

  always @(negedge clk)
    if (wr_en0 | sf0 | dr0 | cd0) mon(0, wr_en0, wr_row0, wr_col0, wr_glyph0, sf0, dr0, cd0);
  always @(negedge clk)
    if (wr_en1 | sf1 | dr1 | cd1) mon(1, wr_en1, wr_row1, wr_col1, wr_glyph1, sf1, dr1, cd1);

  function automatic logic rdy(input int d);
    return (d == 0) ? if0.in_ready : if1.in_ready;
  endfunction

  task automatic drive(input int d, input logic v, input logic [7:0] c);
    if (d == 0) begin if0.in_valid = v; if0.in_char = c; end
    else        begin if1.in_valid = v; if1.in_char = c; end
  endtask

  // Valid is raised immediately and held until the feeder is ready.
  task automatic send(input int d, input logic [7:0] c);
    int n = 0;
    @(negedge clk);
    drive(d, 1'b1, c);
    while (!rdy(d) && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) check("send_ready_timeout", n, 0);
    @(posedge clk);
    #1 drive(d, 1'b0, c);
  endtask

  task automatic wait_drain(input int d);
    int n = 0;
    while (((d == 0) ? q0.size() : q1.size()) > 0 && n < 1000) begin
      @(negedge clk);
      #1 n++;
    end
    if (n >= 1000) check("drain_timeout", (d == 0) ? q0.size() : q1.size(), 0);
  endtask

  logic [7:0] ch5 [5] = '{8'h41, 8'h7A, 8'h35, 8'h81, 8'h7E};
  int         g5  [5] = '{10, 61, 5, 63, 128};

  initial begin
    int n, bad;
    logic [7:0] ch;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    #2 rst0_n = 1'b0; rst1_n = 1'b0;
    #1;
    check("reset_wr_en", wr_en0, 0);
    check("reset_in_ready", if0.in_ready, 0);
    check("reset_cursor", {cur_row0, cur_col0}, 0);
    check("reset_flags", {sf0, dr0, cd0}, 0);
    push_clear(0, 140);
    push_clear(1, 140);
    repeat (2) @(negedge clk);
    rst0_n = 1'b1;
    rst1_n = 1'b1;

    n = 0; bad = 0;
    do begin
      @(negedge clk);
      if (if0.in_ready) bad++;
      n++;
    end while (!cd0 && n < 300);
    check("rdy_low_during_sweep", bad, 0);
    check("sweep_cycles", n, 140);
    @(negedge clk);
    check("rdy_after_sweep", if0.in_ready, 1);

    // Mapping of a mixed set of codes.
    for (int i = 0; i < 5; i++) begin
      push(0, wev(0, i, g5[i], 1'b0, 1'b0));
      send(0, ch5[i]);
      if (i == 0) check("latency_wr_en", {wr_en0, wr_glyph0}, {1'b1, 8'd10});
    end
    check("cursor_after_map", {cur_row0, cur_col0}, {3'd0, 5'd5});

    // Full screen in wrap mode.
    push_clear(0, 140);
    send(0, 8'hFF);
    wait_drain(0);
    check("cursor_after_clear", {cur_row0, cur_col0}, 0);
    for (int i = 0; i < 141; i++) begin
      ch = 8'(97 + i % 26);
      push(0, wev((i % 140) / 20, i % 20, 36 + i % 26, i == 139, 1'b0));
      send(0, ch);
      if (i == 139) check("cursor_wrapped", {cur_row0, cur_col0}, 0);
    end
    check("cursor_after_141", {cur_row0, cur_col0}, {3'd0, 5'd1});

    // Newline and backspace around a row boundary.
    push_clear(0, 140);
    send(0, 8'hFF);
    wait_drain(0);
    for (int i = 0; i < 45; i++) begin
      push(0, wev(i / 20, i % 20, i % 10, 1'b0, 1'b0));
      send(0, 8'(48 + i % 10));
    end
    check("cursor_2_5", {cur_row0, cur_col0}, {3'd2, 5'd5});
    send(0, 8'h0A);
    check("lf_no_write", wr_en0, 0);
    check("cursor_after_lf", {cur_row0, cur_col0}, {3'd3, 5'd0});
    push(0, wev(2, 19, 8'hFE, 1'b0, 1'b0));
    send(0, 8'h08);
    check("cursor_after_bs", {cur_row0, cur_col0}, {3'd2, 5'd19});
    push_clear(0, 140);
    send(0, 8'hFF);
    wait_drain(0);
    send(0, 8'h08);
    check("bs_origin_no_write", wr_en0, 0);
    check("bs_origin_cursor", {cur_row0, cur_col0}, 0);

    // Stop mode on dut1.
    wait_drain(1);
    for (int i = 0; i < 141; i++) begin
      if (i < 140) push(1, wev(i / 20, i % 20, 10 + i % 26, i == 139, 1'b0));
      else         push(1, fev(1'b0, 1'b1));
      send(1, 8'(65 + i % 26));
      if (i == 140) check("drop_no_write", wr_en1, 0);
    end
    check("full_cursor", {cur_row1, cur_col1}, {3'd6, 5'd19});
    check("full_in_ready", if1.in_ready, 1);
    push(1, wev(6, 19, 8'hFE, 1'b0, 1'b0));
    send(1, 8'h08);
    check("full_bs_cursor", {cur_row1, cur_col1}, {3'd6, 5'd19});
    push(1, wev(6, 19, 11, 1'b1, 1'b0));
    send(1, 8'h42);
    push(1, fev(1'b0, 1'b1));
    send(1, 8'h0A);
    wait_drain(1);

    // Reset in the middle of a sweep restarts it from the origin.
    push(0, wev(0, 0, 26, 1'b0, 1'b0));
    send(0, 8'h51);
    push(0, wev(0, 1, 27, 1'b0, 1'b0));
    send(0, 8'h52);
    push_clear(0, 30);
    send(0, 8'hFF);
    wait_drain(0);
    check("cursor_mid_sweep", {cur_row0, cur_col0}, {3'd0, 5'd2});
    rst0_n = 1'b0;
    #1;
    check("async_rst_wr_en", wr_en0, 0);
    check("async_rst_cursor", {cur_row0, cur_col0}, 0);
    push_clear(0, 140);
    repeat (2) @(negedge clk);
    rst0_n = 1'b1;
    wait_drain(0);
    repeat (3) @(negedge clk);
    check("q0_empty", q0.size(), 0);
    check("q1_empty", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
